// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - shared types and constants for the instruction TLB
package tlb_pkg;

  localparam int MISS_COUNT_W = 16;

  // Page-number fields are sized for the widest supported page number;
  // narrower configurations keep the upper bits at zero.
  localparam int PN_MAX_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } state_t;

  typedef struct packed {
    logic                valid;
    logic [PN_MAX_W-1:0] vpn;
    logic [PN_MAX_W-1:0] ppn;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_lookup.sv
// rtl/tlb_lookup.sv - combinational CAM compare over all TLB entries
module tlb_lookup
  import tlb_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0]  valid,
  input  logic [PN_MAX_W-1:0] vpns [ENTRIES],
  input  logic [PN_MAX_W-1:0] vpn,
  output logic                any_match,
  output logic [IDX_W-1:0]    idx
);

  // Entries are unique, so at most one compare succeeds and the loop
  // order does not matter for the index.
  always_comb begin
    any_match = 1'b0;
    idx       = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid[i] && (vpns[i] == vpn)) begin
        any_match = 1'b1;
        idx       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/itlb_assoc.sv
// rtl/itlb_assoc.sv - fully-associative instruction TLB with emulated page walk
module itlb_assoc
  import tlb_pkg::*;
#(
  parameter int ENTRIES      = 4,
  parameter int VA_WIDTH     = 32,
  parameter int PAGE_BITS    = 10,
  parameter int MISS_LATENCY = 10,
  parameter int PPN_OFFSET   = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic [VA_WIDTH-1:0]     virt_addr_in,
  input  logic                    flush,
  output logic [VA_WIDTH-1:0]     phys_addr_out,
  output logic                    hit,
  output logic                    iTLB_stall,
  output logic [MISS_COUNT_W-1:0] miss_count
);

  localparam int VPN_W = VA_WIDTH - PAGE_BITS;
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;

  state_t                  state_q, state_d;
  tlb_entry_t              entry_q [ENTRIES];
  tlb_entry_t              entry_d [ENTRIES];
  logic [VPN_W-1:0]        walk_vpn_q, walk_vpn_d;
  logic [CNT_W-1:0]        walk_cnt_q, walk_cnt_d;
  logic [IDX_W-1:0]        victim_ptr_q, victim_ptr_d;
  logic [MISS_COUNT_W-1:0] miss_count_q, miss_count_d;

  logic [VPN_W-1:0]    req_vpn;
  logic [VPN_W-1:0]    fill_ppn;
  logic [ENTRIES-1:0]  valid_vec;
  logic [PN_MAX_W-1:0] vpn_vec [ENTRIES];
  logic                any_match;
  logic [IDX_W-1:0]    match_idx;

  assign req_vpn    = virt_addr_in[VA_WIDTH-1:PAGE_BITS];
  assign fill_ppn   = VPN_W'(walk_vpn_q + VPN_W'(PPN_OFFSET));
  assign miss_count = miss_count_q;

  // Present the tag side of the entry array to the CAM.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      valid_vec[i] = entry_q[i].valid;
      vpn_vec[i]   = entry_q[i].vpn;
    end
  end

  tlb_lookup #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_lookup (
    .valid     (valid_vec),
    .vpns      (vpn_vec),
    .vpn       (PN_MAX_W'(req_vpn)),
    .any_match (any_match),
    .idx       (match_idx)
  );

  // Lookup outputs, walk sequencing, victim fill and flush override.
  always_comb begin
    state_d       = state_q;
    entry_d       = entry_q;
    walk_vpn_d    = walk_vpn_q;
    walk_cnt_d    = walk_cnt_q;
    victim_ptr_d  = victim_ptr_q;
    miss_count_d  = miss_count_q;
    hit           = 1'b0;
    iTLB_stall    = 1'b0;
    phys_addr_out = '0;

    case (state_q)
      IDLE: begin
        hit        = req_valid && any_match;
        iTLB_stall = req_valid && !any_match;
        if (hit) begin
          phys_addr_out = VA_WIDTH'({entry_q[match_idx].ppn, virt_addr_in[PAGE_BITS-1:0]});
        end
        if (iTLB_stall && !flush) begin
          state_d    = WALK;
          walk_vpn_d = req_vpn;
          walk_cnt_d = '0;
          if (miss_count_q != '1) begin
            miss_count_d = miss_count_q + MISS_COUNT_W'(1);
          end
        end
      end
      WALK: begin
        iTLB_stall = 1'b1;
        walk_cnt_d = walk_cnt_q + CNT_W'(1);
        if (walk_cnt_q == CNT_W'(MISS_LATENCY - 1)) begin
          entry_d[victim_ptr_q].valid = 1'b1;
          entry_d[victim_ptr_q].vpn   = PN_MAX_W'(walk_vpn_q);
          entry_d[victim_ptr_q].ppn   = PN_MAX_W'(fill_ppn);
          victim_ptr_d = victim_ptr_q + IDX_W'(1);
          walk_cnt_d   = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over any fill or walk start computed above.
    if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_d[i].valid = 1'b0;
      end
      victim_ptr_d = '0;
      walk_cnt_d   = '0;
      state_d      = IDLE;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      walk_vpn_q   <= '0;
      walk_cnt_q   <= '0;
      victim_ptr_q <= '0;
      miss_count_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      walk_vpn_q   <= walk_vpn_d;
      walk_cnt_q   <= walk_cnt_d;
      victim_ptr_q <= victim_ptr_d;
      miss_count_q <= miss_count_d;
      entry_q      <= entry_d;
    end
  end

endmodule

// File: tb/tb_itlb_assoc.sv
// tb/tb_itlb_assoc.sv - scoreboard bench for itlb_assoc against a behavioural model
module tb_itlb_assoc;

  localparam int PB    = 10;
  localparam int ML    = 10;
  localparam int E     = 4;
  localparam int VMASK = (1 << 22) - 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, fl0, req1, fl1;
  logic [31:0] va0, va1;
  logic [31:0] phys0, phys1;
  logic        hit0, hit1, st0, st1;
  logic [15:0] mc0, mc1;

  always #5 clock = ~clock;

  itlb_assoc #(.ENTRIES(4), .VA_WIDTH(32), .PAGE_BITS(10), .MISS_LATENCY(10), .PPN_OFFSET(0)) dut0 (
    .clock(clock), .reset(reset), .req_valid(req0), .virt_addr_in(va0), .flush(fl0),
    .phys_addr_out(phys0), .hit(hit0), .iTLB_stall(st0), .miss_count(mc0));

  itlb_assoc #(.ENTRIES(4), .VA_WIDTH(32), .PAGE_BITS(10), .MISS_LATENCY(10), .PPN_OFFSET(3)) dut1 (
    .clock(clock), .reset(reset), .req_valid(req1), .virt_addr_in(va1), .flush(fl1),
    .phys_addr_out(phys1), .hit(hit1), .iTLB_stall(st1), .miss_count(mc1));

  typedef struct packed {
    logic             chk;
    logic [1:0]       hit;
    logic [1:0]       stall;
    logic [1:0][31:0] phys;
    logic [1:0][15:0] mc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: a FIFO-replaced set of cached page numbers, a walk
  // countdown and a saturating miss tally, per instance.
  bit mv   [2][E];
  int mvpn [2][E];
  int mptr [2];
  int mrem [2];
  int mwvpn[2];
  int mcnt [2];
  int off  [2] = '{0, 3};

  task automatic model_cycle(input int k, input bit rq, input logic [31:0] va,
                             input bit fl, input bit rst, inout exp_t e);
    int vpn;
    int hi;
    bit m;
    vpn = int'(va >> PB);
    m = 1'b0;
    hi = 0;
    for (int i = 0; i < E; i++) begin
      if (mv[k][i] && mvpn[k][i] == vpn) begin
        m = 1'b1;
        hi = i;
      end
    end
    e.mc[k] = 16'(mcnt[k]);
    if (mrem[k] > 0) begin
      e.hit[k] = 1'b0;
      e.stall[k] = 1'b1;
      e.phys[k] = 32'h0;
    end else begin
      e.hit[k] = rq && m;
      e.stall[k] = rq && !m;
      e.phys[k] = (rq && m) ? ((32'((mvpn[k][hi] + off[k]) & VMASK) << PB) | (va & 32'h3FF)) : 32'h0;
    end
    if (rst) begin
      for (int i = 0; i < E; i++) mv[k][i] = 1'b0;
      mptr[k] = 0; mrem[k] = 0; mcnt[k] = 0;
    end else if (fl) begin
      for (int i = 0; i < E; i++) mv[k][i] = 1'b0;
      mptr[k] = 0; mrem[k] = 0;
    end else if (mrem[k] > 0) begin
      mrem[k] = mrem[k] - 1;
      if (mrem[k] == 0) begin
        mv[k][mptr[k]] = 1'b1;
        mvpn[k][mptr[k]] = mwvpn[k];
        mptr[k] = (mptr[k] + 1) % E;
      end
    end else if (rq && !m) begin
      mrem[k] = ML;
      mwvpn[k] = vpn;
      if (mcnt[k] < 65535) mcnt[k] = mcnt[k] + 1;
    end
  endtask

  // One clock of stimulus on instance k; the other instance idles.
  task automatic step(input int k, input bit rq, input logic [31:0] va, input bit fl, input bit rst = 1'b0);
    exp_t e;
    @(posedge clock);
    #1;
    e = '0;
    e.chk = !rst;
    reset = rst;
    req0 = (k == 0) ? rq : 1'b0;
    va0  = (k == 0) ? va : 32'h0;
    fl0  = (k == 0) ? fl : 1'b0;
    req1 = (k == 1) ? rq : 1'b0;
    va1  = (k == 1) ? va : 32'h0;
    fl1  = (k == 1) ? fl : 1'b0;
    model_cycle(0, req0, va0, fl0, rst, e);
    model_cycle(1, req1, va1, fl1, rst, e);
    sbq.push_back(e);
  endtask

  task automatic hold(input int k, input logic [31:0] va, input int n);
    for (int i = 0; i < n; i++) step(k, 1'b1, va, 1'b0);
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per cycle and checks both instances.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.chk) begin
          cmp("hit0",   32'(hit0),  32'(e.hit[0]));
          cmp("stall0", 32'(st0),   32'(e.stall[0]));
          cmp("phys0",  phys0,      e.phys[0]);
          cmp("mc0",    32'(mc0),   32'(e.mc[0]));
          cmp("hit1",   32'(hit1),  32'(e.hit[1]));
          cmp("stall1", 32'(st1),   32'(e.stall[1]));
          cmp("phys1",  phys1,      e.phys[1]);
          cmp("mc1",    32'(mc1),   32'(e.mc[1]));
        end
      end
    end
  end

  initial begin
    logic [31:0] pages [4];
    logic [31:0] rva;
    pages[0] = 32'h0400; pages[1] = 32'h0800; pages[2] = 32'h0C00; pages[3] = 32'h1000;
    reset = 1'b1;
    req0 = 1'b0; va0 = 32'h0; fl0 = 1'b0;
    req1 = 1'b0; va1 = 32'h0; fl1 = 1'b0;

    step(0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(0, 1'b1, 32'h0, 1'b0, 1'b1);
    hold(0, 32'h0000_1234, 12);

    step(0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int p = 0; p < 4; p++) hold(0, pages[p], 12);
    for (int p = 0; p < 4; p++) hold(0, pages[p], 1);
    hold(0, 32'h1400, 12);
    hold(0, 32'h0400, 12);
    hold(0, 32'h0C00, 2);

    hold(0, 32'h1800, 6);
    step(0, 1'b1, 32'h1800, 1'b1);
    hold(0, 32'h1400, 12);

    hold(0, 32'h2000, 1);
    hold(0, 32'h2400, 10);
    hold(0, 32'h2000, 1);
    hold(0, 32'h2400, 12);

    for (int i = 0; i < 3; i++) step(0, 1'b0, 32'h2000, 1'b0);
    step(0, 1'b1, 32'h3000, 1'b1);
    hold(0, 32'h3000, 2);

    for (int i = 0; i < 2000; i++) begin
      rva = {19'h0, 3'($urandom_range(0, 7)), 10'($urandom)};
      step(0, ($urandom % 4) != 0, rva, ($urandom % 60) == 0);
    end

    hold(1, 32'h0000_0C05, 12);
    step(1, 1'b0, 32'h0, 1'b0);

    @(negedge clock);
    #1;
    force dut1.miss_count_q = 16'hFFFD;
    #1;
    release dut1.miss_count_q;
    mcnt[1] = 16'hFFFD;
    for (int i = 0; i < 5; i++) begin
      step(1, 1'b1, 32'h0001_0000 + 32'(i) * 32'h400, 1'b0);
      step(1, 1'b0, 32'h0, 1'b1);
    end
    step(1, 1'b0, 32'h0, 1'b0);

    repeat (3) @(negedge clock);
    #1;
    cmp("sb_drained", 32'(sbq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/itlb_assoc.md
# itlb_assoc

Parametrised, fully-associative instruction TLB for the fetch stage, sitting between the PC/fetch unit and the instruction cache. It holds ENTRIES translations, stalls fetch on a miss while a fixed-latency emulated page walk runs, then fills a victim entry chosen FIFO. It adds flush, a hit output and a miss counter over the single-entry TLB.

## Interface
- ENTRIES, 4: number of translation entries; power of two, at least 2.
- VA_WIDTH, 32: virtual and physical address width.
- PAGE_BITS, 10: page-offset width; VPN/PPN width is VA_WIDTH-PAGE_BITS.
- MISS_LATENCY, 10: page-walk cycles; at least 1.
- PPN_OFFSET, 0: walk result is ppn = vpn + PPN_OFFSET, modulo 2^(VA_WIDTH-PAGE_BITS).
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- req_valid  input  1  a fetch translation is requested this cycle.
- virt_addr_in  input  VA_WIDTH  virtual fetch address.
- flush  input  1  invalidates all entries (synchronous).
- phys_addr_out  output  VA_WIDTH  translated address; 0 when hit is 0.
- hit  output  1  req_valid is high and a valid entry matches the VPN.
- iTLB_stall  output  1  fetch must hold its current address.
- miss_count  output  16  number of walks started; saturates at 16'hFFFF.

## Operation
- Lookup is combinational:
  - match[i] = valid[i] && vpn[i] == virt_addr_in[VA_WIDTH-1:PAGE_BITS].
  - hit = req_valid && |match && state==IDLE.
  - phys_addr_out = {ppn[idx], virt_addr_in[PAGE_BITS-1:0]} when hit is 1, otherwise 0.
- Entries are unique by construction, so at most one match bit is set.
- FSM states: IDLE and WALK.
- IDLE:
  - iTLB_stall = req_valid && !|match.
  - On that miss condition (and flush=0): go to WALK, latch the VPN into walk_vpn, clear walk_cnt, increment miss_count.
- WALK:
  - iTLB_stall = 1 and hit = 0.
  - walk_cnt increments each cycle.
  - When walk_cnt == MISS_LATENCY-1: write the entry at victim_ptr (valid=1, vpn=walk_vpn, ppn=walk_vpn+PPN_OFFSET), advance victim_ptr modulo ENTRIES, return to IDLE.
- The fill always uses the latched walk_vpn; changes on virt_addr_in during WALK are ignored.
- After returning to IDLE, a different VPN that misses starts a new walk.
- flush:
  - Has priority over everything else: valid bits cleared, victim_ptr=0, walk_cnt=0, state goes to IDLE next cycle.
  - A walk in progress is aborted with no fill.
  - A miss seen in the same cycle does not start a walk and does not count.
  - miss_count is unaffected.
- req_valid=0 in IDLE: no stall, no walk; phys_addr_out=0, hit=0.
- Replacement when full: the FIFO victim is overwritten. The victim may be the entry just used; that is acceptable.

## Timing
- Reset (synchronous): state=IDLE, all valid=0, victim_ptr=0, walk_cnt=0, miss_count=0, walk_vpn=0, vpn/ppn arrays=0.
  - After the reset edge: hit=0, phys_addr_out=0, iTLB_stall=req_valid.
- A reset asserted mid-walk behaves like flush and also clears miss_count.
- Hit: zero-latency combinational; iTLB_stall=0 in the same cycle.
- Miss detected in cycle 0:
  - iTLB_stall is high in cycles 0..MISS_LATENCY, i.e. MISS_LATENCY+1 cycles.
  - The fill happens on the clock edge that ends cycle MISS_LATENCY.
  - The same address hits in cycle MISS_LATENCY+1.
  - With the defaults: stall in cycles 0..10, hit in cycle 11.
- miss_count updates on the edge ending the miss cycle.
- No combinational path from virt_addr_in to registered state other than the walk_vpn capture and the miss decision.

## Structure
- Package tlb_pkg holds:
  - the state_t enum (IDLE, WALK);
  - a parameterisable entry struct (valid, vpn, ppn);
  - the localparam MISS_COUNT_W=16.
- Sub-module tlb_lookup: combinational CAM compare over the ENTRIES entries. It outputs any_match and a binary index for the ppn mux.
- The top level owns the FSM, walk counter, victim pointer, entry registers and miss counter.

## Test plan
- Reset then cold fetch of VA 32'h0000_1234 with req_valid=1:
  - stall in cycles 0..10 and hit=0;
  - cycle 11: hit=1, phys=32'h0000_1234 (PPN_OFFSET=0), miss_count=1.
- Fill 4 distinct pages 0x0400, 0x0800, 0x0C00, 0x1000 (4 walks), then revisit all four: each hits with zero stall, miss_count=4.
- Fifth page 0x1400:
  - walk, then overwrite of entry 0 (page 0x0400);
  - re-fetch 0x0400: miss and walk, replacing entry 1 (page 0x0800);
  - miss_count=6.
- Flush asserted in walk cycle 5:
  - stall drops the next cycle and no fill occurs;
  - a previously valid page now misses;
  - miss_count is unchanged by the flush.
- virt_addr_in changed to a new page mid-walk:
  - the fill uses the original VPN and the original page hits afterwards;
  - the new page then takes its own 11-cycle stall.
- PPN_OFFSET=3, VA 32'h0000_0C05: after the walk, phys=32'h0000_1805.
  - Also drive 65536+ misses and check miss_count saturates at 16'hFFFF.
